grf_wport_arb: RTL and testbench
================================

# grf_wport_arb

Write-port arbiter for the 32×32 general register file in the pipelined MIPS core. Shares the GRF's single write port between the W-stage writeback (fixed priority, never stalled) and an auxiliary multi-cycle result source. The auxiliary source is fed through a small pending-write FIFO. The block also reports pending-write hazards to the hazard unit, kills stale pending writes, and requests a pipeline bubble when the auxiliary path starves.

## Interface
Parameters:
- DEPTH, 4, pending FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, blocked-drain cycles before stall_req; 1..255

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- p_we  in  1  W-stage write enable
- p_addr  in  5  W-stage destination register
- p_wd  in  32  W-stage write data
- p_pc  in  32  W-stage PC, for trace
- x_valid  in  1  auxiliary result valid
- x_ready  out  1  auxiliary result accepted this cycle when high with x_valid
- x_addr  in  5  auxiliary destination register
- x_wd  in  32  auxiliary result data
- x_pc  in  32  auxiliary instruction PC
- rd_a1  in  5  D-stage read address 1
- rd_a2  in  5  D-stage read address 2
- pend_hit1  out  1  rd_a1 is nonzero and matches a live FIFO entry
- pend_hit2  out  1  rd_a2 is nonzero and matches a live FIFO entry
- stall_req  out  1  request that the pipeline hold p_we low
- regWrite  out  1  GRF write enable
- A3  out  5  GRF write address
- WD  out  32  GRF write data
- wpc  out  32  GRF trace PC

## Operation
- **Entry format:** each FIFO entry holds {live, addr, wd, pc}. count ranges 0..DEPTH.
- **x_ready:** x_ready = (count < DEPTH), taken from registered state only; there is no same-cycle pass-through.
- **Accept:** a beat is accepted when x_valid && x_ready.
  - x_addr==0: beat is accepted and discarded, not enqueued.
  - Otherwise: beat is enqueued with live=1.
- **Port select (combinational), in priority order:**
  - p_we && p_addr!=0: regWrite=1; A3/WD/wpc are taken from the p_* inputs.
  - Else, FIFO non-empty and head live: regWrite=1; outputs come from the head entry; head pops at the clock edge.
  - Else: regWrite=0; A3, WD, wpc are all 0.
- **Dead head:** a head with live=0 pops every cycle it is at the head, regardless of P activity, and never drives regWrite.
- **Kill:** on a P write with p_addr!=0, every FIFO entry with addr==p_addr gets live cleared at the clock edge. A same-cycle enqueue with a matching address is also killed (enqueued with live=0). P is always the architecturally newest write.
- **Hazard outputs:** pend_hit1 and pend_hit2 are combinational over live entries only. They do not include the in-flight x beat.
- **Simultaneous accept and pop:** count is unchanged.
- **Full FIFO:** x_ready=0. x_valid is ignored and the source must hold its beat.

## Timing
- **Reset values:** count=0, all live=0, starve counter=0. As a result x_ready=1, stall_req=0, pend_hit1=pend_hit2=0. regWrite/A3/WD/wpc follow the P inputs (0 when p_we=0).
- **Latency:** a beat accepted at edge N reaches the GRF, at the earliest, in the cycle after N (regWrite high, written at edge N+1).
- **Starve counter:**
  - Increments (saturating at STARVE_LIMIT) on each cycle the head is live and blocked by a P write.
  - Clears on every pop.
  - stall_req = (counter == STARVE_LIMIT); it holds until the next pop.
  - The pipeline must drive p_we=0 in the cycle after it sees stall_req.
- **Reset mid-operation:** pending entries are lost without being written. x_ready is high immediately, asynchronously.

## Configuration
- **GRF_ARB_STARVE_EN defined:** the starve counter and stall_req behave as described above.
- **GRF_ARB_STARVE_EN undefined:** no counter is built and stall_req is tied 0. The auxiliary path drains only in P-idle cycles.

## Structure
- **Package grf_arb_pkg:** REG_AW=5, DW=32, and a typedef for the FIFO entry struct {live, addr, wd, pc}.
- **Sub-module grf_arb_fifo:** circular buffer with head/tail pointers, the count, per-entry live bits with a kill-by-address port, and match outputs for two read addresses.
- **Top level:** output mux and starve counter.

## Test plan
- **Reset:** with p_we=0 → x_ready=1, regWrite=0, A3=0, stall_req=0.
- **Idle drain:** x beat {addr=5, wd=0xA5A5_0001} with P idle → regWrite=1, A3=5, WD=0xA5A5_0001 in the next cycle; pend_hit1 is high for rd_a1=5 only during the one cycle the entry is held.
- **Priority:** 4 x beats enqueued while p_we=1 every cycle → x_ready=0 after the 4th beat. After P goes idle, the beats drain in FIFO order over 4 consecutive cycles.
- **Kill:** pending entry addr=8, then a P write to $8 with 0x1234 → GRF gets only 0x1234. The dead entry pops with regWrite=0 and pend_hit for $8 clears.
- **Starvation (macro on, STARVE_LIMIT=8):** live head plus 8 consecutive P writes → stall_req=1. Then p_we=0 → head is written, stall_req=0. With the macro off, stall_req stays 0.
- **$0 handling:** x_addr=0 is accepted but never written; P write to $0 lets the FIFO head drain that same cycle.

Source files
------------

// File: rtl/grf_arb_pkg.sv
// Shared widths and the pending-write FIFO entry type for the GRF write-port arbiter.
package grf_arb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DW     = 32;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] addr;
        logic [DW-1:0]     wd;
        logic [DW-1:0]     pc;
    } grf_entry_t;

endpackage

// File: rtl/grf_arb_fifo.sv
// Pending-write circular buffer: head/tail pointers, per-entry live bits,
// kill-by-address and two hazard match ports over live entries.
module grf_arb_fifo
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  grf_entry_t              i_push_entry,
    input  logic                    i_pop,
    input  logic                    i_kill_en,
    input  logic [REG_AW-1:0]       i_kill_addr,
    input  logic [REG_AW-1:0]       i_rd_a1,
    input  logic [REG_AW-1:0]       i_rd_a2,
    output grf_entry_t              o_head,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_hit1,
    output logic                    o_hit2
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    logic [DEPTH-1:0]  r_live;
    logic [REG_AW-1:0] r_addr [DEPTH];
    logic [DW-1:0]     r_wd   [DEPTH];
    logic [DW-1:0]     r_pc   [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Live bit cleared on pop so that live always implies an occupied slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_pop && (PW'(i) == r_head))
                    r_live[i] <= 1'b0;
                else if (i_kill_en && (r_addr[i] == i_kill_addr))
                    r_live[i] <= 1'b0;
                if (i_push && (PW'(i) == r_tail))
                    r_live[i] <= i_push_entry.live;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_entry.addr;
            r_wd[r_tail]   <= i_push_entry.wd;
            r_pc[r_tail]   <= i_push_entry.pc;
        end
    end

    always_comb begin
        o_head.live = r_live[r_head];
        o_head.addr = r_addr[r_head];
        o_head.wd   = r_wd[r_head];
        o_head.pc   = r_pc[r_head];
    end

    assign o_count = r_count;

    always_comb begin
        o_hit1 = 1'b0;
        o_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_addr[i] == i_rd_a1)) o_hit1 = 1'b1;
            if (r_live[i] && (r_addr[i] == i_rd_a2)) o_hit2 = 1'b1;
        end
        o_hit1 = o_hit1 && (i_rd_a1 != '0);
        o_hit2 = o_hit2 && (i_rd_a2 != '0);
    end

endmodule

// File: rtl/grf_wport_arb.sv
// GRF write-port arbiter: W-stage writes win, auxiliary results drain from a pending FIFO.
// Optional starvation counter / stall_req enabled by defining GRF_ARB_STARVE_EN.
module grf_wport_arb
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p_we,
    input  logic [REG_AW-1:0] p_addr,
    input  logic [DW-1:0]     p_wd,
    input  logic [DW-1:0]     p_pc,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [REG_AW-1:0] x_addr,
    input  logic [DW-1:0]     x_wd,
    input  logic [DW-1:0]     x_pc,
    input  logic [REG_AW-1:0] rd_a1,
    input  logic [REG_AW-1:0] rd_a2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              stall_req,
    output logic              regWrite,
    output logic [REG_AW-1:0] A3,
    output logic [DW-1:0]     WD,
    output logic [DW-1:0]     wpc
);

    localparam int unsigned PW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("grf_wport_arb: DEPTH must be a power of two >= 2");
    end
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
        $error("grf_wport_arb: STARVE_LIMIT must be 1..255");
    end

    logic        w_p_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_head_live;
    logic [PW:0] w_count;
    grf_entry_t  w_push_entry;
    grf_entry_t  w_head;

    assign w_p_wr  = p_we && (p_addr != '0);
    assign x_ready = (w_count < (PW+1)'(DEPTH));
    assign w_push  = x_valid && x_ready && (x_addr != '0);
    assign w_empty = (w_count == '0);
    assign w_head_live = !w_empty && w_head.live;
    // Dead heads always retire; live heads only when P leaves the port free.
    assign w_pop = !w_empty && (!w_head.live || !w_p_wr);

    always_comb begin
        w_push_entry.live = !(w_p_wr && (x_addr == p_addr));
        w_push_entry.addr = x_addr;
        w_push_entry.wd   = x_wd;
        w_push_entry.pc   = x_pc;
    end

    grf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_p_wr),
        .i_kill_addr  (p_addr),
        .i_rd_a1      (rd_a1),
        .i_rd_a2      (rd_a2),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_hit1       (pend_hit1),
        .o_hit2       (pend_hit2)
    );

    always_comb begin
        regWrite = 1'b0;
        A3       = '0;
        WD       = '0;
        wpc      = '0;
        if (w_p_wr) begin
            regWrite = 1'b1;
            A3       = p_addr;
            WD       = p_wd;
            wpc      = p_pc;
        end else if (w_head_live) begin
            regWrite = 1'b1;
            A3       = w_head.addr;
            WD       = w_head.wd;
            wpc      = w_head.pc;
        end
    end

`ifdef GRF_ARB_STARVE_EN
    logic [7:0] r_starve;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_starve <= '0;
        else if (w_pop)
            r_starve <= '0;
        else if (w_head_live && w_p_wr && (r_starve != 8'(STARVE_LIMIT)))
            r_starve <= r_starve + 8'd1;
    end

    assign stall_req = (r_starve == 8'(STARVE_LIMIT));
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wport_arb.sv
// Directed vector bench for grf_wport_arb; starvation expectations follow GRF_ARB_STARVE_EN.
module tb_grf_wport_arb;

    import grf_arb_pkg::*;

`ifdef GRF_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              p_we;
    logic [REG_AW-1:0] p_addr;
    logic [DW-1:0]     p_wd;
    logic [DW-1:0]     p_pc;
    logic              x_valid;
    logic              x_ready;
    logic [REG_AW-1:0] x_addr;
    logic [DW-1:0]     x_wd;
    logic [DW-1:0]     x_pc;
    logic [REG_AW-1:0] rd_a1;
    logic [REG_AW-1:0] rd_a2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic              stall_req;
    logic              regWrite;
    logic [REG_AW-1:0] A3;
    logic [DW-1:0]     WD;
    logic [DW-1:0]     wpc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    grf_wport_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wd      (p_wd),
        .p_pc      (p_pc),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_addr    (x_addr),
        .x_wd      (x_wd),
        .x_pc      (x_pc),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .stall_req (stall_req),
        .regWrite  (regWrite),
        .A3        (A3),
        .WD        (WD),
        .wpc       (wpc)
    );

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pwd;
        logic [31:0] ppc;
        logic        xv;
        logic [4:0]  xa;
        logic [31:0] xwd;
        logic [31:0] xpc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_xr;
        logic        e_h1;
        logic        e_h2;
        logic        e_rw;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_wpc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addv(input logic pwe, input logic [4:0] pa, input logic [31:0] pwd, input logic [31:0] ppc,
                        input logic xv, input logic [4:0] xa, input logic [31:0] xwd, input logic [31:0] xpc,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic e_xr, input logic e_h1, input logic e_h2, input logic e_rw,
                        input logic [4:0] e_a3, input logic [31:0] e_wd, input logic [31:0] e_wpc);
        vec_t v;
        v.pwe = pwe;   v.pa = pa;     v.pwd = pwd;   v.ppc = ppc;
        v.xv = xv;     v.xa = xa;     v.xwd = xwd;   v.xpc = xpc;
        v.r1 = r1;     v.r2 = r2;
        v.e_xr = e_xr; v.e_h1 = e_h1; v.e_h2 = e_h2; v.e_rw = e_rw;
        v.e_a3 = e_a3; v.e_wd = e_wd; v.e_wpc = e_wpc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pwd, input logic [31:0] ppc,
                         input logic xv, input logic [4:0] xa, input logic [31:0] xwd, input logic [31:0] xpc,
                         input logic [4:0] r1, input logic [4:0] r2);
        p_we = pwe;  p_addr = pa;  p_wd = pwd;  p_pc = ppc;
        x_valid = xv; x_addr = xa; x_wd = xwd; x_pc = xpc;
        rd_a1 = r1;  rd_a2 = r2;
    endtask

    task automatic chk_port(input string tag, input logic e_rw, input logic [4:0] e_a3,
                            input logic [31:0] e_wd, input logic [31:0] e_wpc);
        chk({tag, ".regWrite"}, 32'(regWrite), 32'(e_rw));
        chk({tag, ".A3"},       32'(A3),       32'(e_a3));
        chk({tag, ".WD"},       WD,            e_wd);
        chk({tag, ".wpc"},      wpc,           e_wpc);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // pwe pa pwd ppc | xv xa xwd xpc | r1 r2 | xr h1 h2 rw a3 wd wpc
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       0,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 1, 5,  32'hA5A5_0001, 32'h100, 5,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       5,  0,  1, 1, 0, 1, 5,  32'hA5A5_0001, 32'h100);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       5,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(1, 1, 32'h1111, 32'h200,    1, 10, 32'hB0,       32'h300, 0,  0,  1, 0, 0, 1, 1,  32'h1111,     32'h200);
        addv(1, 2, 32'h2222, 32'h204,    1, 11, 32'hB1,       32'h304, 10, 11, 1, 1, 0, 1, 2,  32'h2222,     32'h204);
        addv(1, 3, 32'h3333, 32'h208,    1, 12, 32'hB2,       32'h308, 10, 11, 1, 1, 1, 1, 3,  32'h3333,     32'h208);
        addv(1, 4, 32'h4444, 32'h20C,    1, 13, 32'hB3,       32'h30C, 12, 13, 1, 1, 0, 1, 4,  32'h4444,     32'h20C);
        addv(1, 6, 32'h6666, 32'h210,    1, 14, 32'hB4,       32'h310, 13, 14, 0, 1, 0, 1, 6,  32'h6666,     32'h210);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       10, 13, 0, 1, 1, 1, 10, 32'hB0,       32'h300);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       10, 11, 1, 0, 1, 1, 11, 32'hB1,       32'h304);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       12, 0,  1, 1, 0, 1, 12, 32'hB2,       32'h308);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       13, 12, 1, 1, 0, 1, 13, 32'hB3,       32'h30C);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       13, 0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 1, 8,  32'hDEAD,     32'h400, 8,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(1, 8, 32'h1234, 32'h500,    0, 0,  0,            0,       8,  0,  1, 1, 0, 1, 8,  32'h1234,     32'h500);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       8,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       8,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(1, 9, 32'h99, 32'h600,      1, 9,  32'hBAD,      32'h604, 9,  0,  1, 0, 0, 1, 9,  32'h99,       32'h600);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       9,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       9,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 1, 0,  32'hFFFF,     32'h700, 0,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       0,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(0, 0, 0, 0,                 1, 7,  32'h77,       32'h710, 7,  0,  1, 0, 0, 0, 0,  0,            0);
        addv(1, 0, 32'hEEEE, 32'h720,    0, 0,  0,            0,       0,  7,  1, 0, 1, 1, 7,  32'h77,       32'h710);
        addv(0, 0, 0, 0,                 0, 0,  0,            0,       0,  7,  1, 0, 0, 0, 0,  0,            0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clk);
            drive(vecs[i].pwe, vecs[i].pa, vecs[i].pwd, vecs[i].ppc,
                  vecs[i].xv, vecs[i].xa, vecs[i].xwd, vecs[i].xpc, vecs[i].r1, vecs[i].r2);
            #2;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".x_ready"},   32'(x_ready),   32'(vecs[i].e_xr));
            chk({tag, ".pend_hit1"}, 32'(pend_hit1), 32'(vecs[i].e_h1));
            chk({tag, ".pend_hit2"}, 32'(pend_hit2), 32'(vecs[i].e_h2));
            chk({tag, ".stall_req"}, 32'(stall_req), 32'd0);
            chk_port(tag, vecs[i].e_rw, vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_wpc);
        end

        // Starvation: one live head held off by eight consecutive P writes.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 20, 32'h2020, 32'h800, 20, 0);
        #2;
        chk("starve.enq.regWrite", 32'(regWrite), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1, 21, 32'h2100 + 32'(k), 32'h900, 0, 0, 0, 0, 20, 0);
            #2;
            chk($sformatf("starve.blk%0d.stall_req", k), 32'(stall_req), 32'd0);
            chk($sformatf("starve.blk%0d.A3", k), 32'(A3), 32'd21);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 20, 0);
        #2;
        chk("starve.hold.stall_req", 32'(stall_req), 32'(STARVE_ON));
        chk("starve.hold.pend_hit1", 32'(pend_hit1), 32'd1);
        chk_port("starve.drain", 1'b1, 5'd20, 32'h2020, 32'h800);
        @(negedge clk);
        #2;
        chk("starve.after.stall_req", 32'(stall_req), 32'd0);
        chk("starve.after.regWrite", 32'(regWrite), 32'd0);

        // Asynchronous reset with a full FIFO: entries lost, x_ready high at once.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 1, 32'h1, 32'h0, 1, 5'(24 + k), 32'hC0 + 32'(k), 32'hA00, 24, 27);
            #2;
            chk($sformatf("rst.fill%0d.x_ready", k), 32'(x_ready), 32'd1);
        end
        @(negedge clk);
        drive(1, 1, 32'h1, 32'h0, 0, 0, 0, 0, 24, 27);
        #2;
        chk("rst.full.x_ready", 32'(x_ready), 32'd0);
        chk("rst.full.pend_hit1", 32'(pend_hit1), 32'd1);
        chk("rst.full.pend_hit2", 32'(pend_hit2), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 24, 27);
        reset = 1'b1;
        #1;
        chk("rst.async.x_ready", 32'(x_ready), 32'd1);
        chk("rst.async.pend_hit1", 32'(pend_hit1), 32'd0);
        chk("rst.async.regWrite", 32'(regWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        chk("rst.after.regWrite", 32'(regWrite), 32'd0);
        chk("rst.after.x_ready", 32'(x_ready), 32'd1);
        chk("rst.after.stall_req", 32'(stall_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
